rr_grant_arbiter: RTL and testbench

Round-robin arbiter that shares one resource between N requesters.
It uses a rotating-priority scan built on a priority encoder that selects the lowest index at or above a pointer. Grants are held while the owner keeps its request asserted, and a hold limit prevents starvation.
It sits in front of any shared datapath (bus port, memory bank, shared ALU) and drives that resource's select/mux lines.

---
 rtl/rr_grant_arbiter_pkg.sv | 15 +
 rtl/rr_grant_arbiter_pick.sv | 41 ++++
 rtl/rr_grant_arbiter.sv | 117 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for round-robin arbitration blocks: FSM encodings and
// the index-width helper.
package rr_grant_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Width of an index into n requesters, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// Rotating-priority picker: first set bit of mask at or above start,
// wrapping modulo N.
module rr_pick
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          mask,
  input  logic [idx_w(N)-1:0]   start,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  found
);

  localparam int unsigned IW = idx_w(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  rel;
  logic [IW:0]    sum;

  // Rotate so start lands at bit 0, encode lowest set bit, then undo rotation.
  always_comb begin
    dbl   = {mask, mask} >> start;
    rot   = dbl[N-1:0];
    rel   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (rot[i] && !found) begin
        rel   = IW'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, rel} + {1'b0, start};
    if (sum >= (IW+1)'(N)) begin
      idx = IW'(sum - (IW+1)'(N));
    end else begin
      idx = sum[IW-1:0];
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with grant hold while requested and a hold limit that
// hands the resource on when others are waiting.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  output logic [N-1:0]          grant,
  output logic [idx_w(N)-1:0]   grant_idx,
  output logic                  grant_valid
);

  localparam int unsigned IW      = idx_w(N);
  localparam int unsigned CW      = (MAX_HOLD + 1 < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned CNT_MAX = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  pick_mask;
  logic [IW-1:0] pick_start;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [IW-1:0] next_ptr;
  logic          others;
  logic          handoff;

  rr_pick #(.N(N)) u_pick (
    .mask  (pick_mask),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: in GRANT the scan excludes the owner and starts just past it.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    next_ptr   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
    others     = |(req & ~grant_q);
    handoff    = 1'b0;
    pick_mask  = req;
    pick_start = ptr_q;

    if (state_q == ST_GRANT) begin
      pick_mask  = req & ~grant_q;
      pick_start = next_ptr;
      handoff    = !req[idx_q] ||
                   ((MAX_HOLD != 0) && (cnt_q == CW'(CNT_MAX)) && others);
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          grant_d = N'(1) << pick_idx;
          idx_d   = pick_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (handoff) begin
          ptr_d = next_ptr;
          cnt_d = '0;
          if (pick_found) begin
            grant_d = N'(1) << pick_idx;
            idx_d   = pick_idx;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end else if (cnt_q != CW'(CNT_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed scoreboard bench for rr_grant_arbiter: N=4 and N=5 instances.
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst4, rst5;
  logic [3:0] req4;
  logic [4:0] req5;
  logic [3:0] grant4;
  logic [1:0] idx4;
  logic       valid4;
  logic [4:0] grant5;
  logic [2:0] idx5;
  logic       valid5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         n;
    logic [4:0] g;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rr_grant_arbiter #(.N(4), .MAX_HOLD(8)) dut4 (
    .clk(clk), .rst(rst4), .req(req4),
    .grant(grant4), .grant_idx(idx4), .grant_valid(valid4)
  );

  rr_grant_arbiter #(.N(5), .MAX_HOLD(8)) dut5 (
    .clk(clk), .rst(rst5), .req(req5),
    .grant(grant5), .grant_idx(idx5), .grant_valid(valid5)
  );

  function automatic logic [2:0] onehot_idx(input logic [4:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 5; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic check_pop();
    exp_t       e;
    logic [4:0] ag;
    logic [2:0] ai;
    logic       av;
    logic [2:0] ei;
    logic       ev;
    e  = sb.pop_front();
    ag = (e.n == 4) ? {1'b0, grant4} : grant5;
    ai = (e.n == 4) ? {1'b0, idx4} : idx5;
    av = (e.n == 4) ? valid4 : valid5;
    ei = onehot_idx(e.g);
    ev = |e.g;
    checks++;
    assert (ag === e.g) else begin
      errors++;
      $error("FAIL %s grant got %b want %b", e.tag, ag, e.g);
    end
    checks++;
    assert (ai === ei) else begin
      errors++;
      $error("FAIL %s grant_idx got %0d want %0d", e.tag, ai, ei);
    end
    checks++;
    assert (av === ev) else begin
      errors++;
      $error("FAIL %s grant_valid got %b want %b", e.tag, av, ev);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected grant after the next edge.
  task automatic step(input int n, input logic r, input logic [4:0] rq,
                      input logic [4:0] eg, input string tag);
    exp_t e;
    if (n == 4) begin
      rst4 = r;
      req4 = rq[3:0];
    end else begin
      rst5 = r;
      req5 = rq;
    end
    e.n = n; e.g = eg; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    rst4 = 1'b1; rst5 = 1'b1; req4 = '0; req5 = '0;

    // Reset with all requests pending.
    step(4, 1'b1, 5'b01111, 5'b00000, "reset0");
    step(4, 1'b1, 5'b01111, 5'b00000, "reset1");
    step(4, 1'b0, 5'b01111, 5'b00001, "first_grant");

    // Rotation without idle bubbles.
    step(4, 1'b0, 5'b01110, 5'b00010, "rot_1");
    step(4, 1'b0, 5'b01111, 5'b00010, "rot_1_hold");
    step(4, 1'b0, 5'b01101, 5'b00100, "rot_2");
    step(4, 1'b0, 5'b01111, 5'b00100, "rot_2_hold");
    step(4, 1'b0, 5'b01011, 5'b01000, "rot_3");
    step(4, 1'b0, 5'b01111, 5'b01000, "rot_3_hold");
    step(4, 1'b0, 5'b00111, 5'b00001, "rot_wrap_0");
    step(4, 1'b0, 5'b00000, 5'b00000, "rot_idle");

    // Uncontended hold beyond the hold limit.
    step(4, 1'b0, 5'b00100, 5'b00100, "hold_start");
    for (int k = 0; k < 20; k++) step(4, 1'b0, 5'b00100, 5'b00100, "hold_long");
    step(4, 1'b0, 5'b00000, 5'b00000, "hold_release");
    step(4, 1'b0, 5'b01001, 5'b01000, "ptr_after_hold");
    step(4, 1'b0, 5'b00000, 5'b00000, "idle_again");

    // Preemption after eight cycles of ownership.
    step(4, 1'b0, 5'b00001, 5'b00001, "pre_start");
    for (int k = 1; k < 8; k++)
      step(4, 1'b0, (k >= 3) ? 5'b00101 : 5'b00001, 5'b00001, "pre_hold");
    step(4, 1'b0, 5'b00101, 5'b00100, "preempt");
    step(4, 1'b0, 5'b00101, 5'b00100, "pre_new_hold");
    step(4, 1'b0, 5'b00001, 5'b00001, "pre_regrant");

    // Mid-operation reset.
    step(4, 1'b0, 5'b01000, 5'b01000, "mid_grant3");
    step(4, 1'b1, 5'b01010, 5'b00000, "mid_reset");
    step(4, 1'b0, 5'b01010, 5'b00010, "post_reset");

    // N=5: walk ptr to 4, then wrap.
    step(5, 1'b1, 5'b00000, 5'b00000, "n5_reset");
    step(5, 1'b0, 5'b01000, 5'b01000, "n5_g3");
    step(5, 1'b0, 5'b00000, 5'b00000, "n5_idle_ptr4");
    step(5, 1'b0, 5'b00011, 5'b00001, "n5_wrap");
    step(5, 1'b0, 5'b00010, 5'b00010, "n5_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
